// File: rtl/imm_decode_skid_pkg.sv
// Shared definitions for the stage-1 decode front end: immediate-type
// encodings, RV32 major opcodes and the skid-buffer occupancy states.
package imm_decode_skid_pkg;

    typedef enum logic [2:0] {
        R_TYPE     = 3'd0,
        I_TYPE     = 3'd1,
        ISTAR_TYPE = 3'd2,
        S_TYPE     = 3'd3,
        B_TYPE     = 3'd4,
        U_TYPE     = 3'd5,
        J_TYPE     = 3'd6
    } imm_type_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Buffer occupancy, doubles as the FSM state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } count_e;

endpackage

// File: rtl/imm_decode_skid_if.sv
// Fetch-side and decode-side handshake bundle for imm_decode_skid.
interface imm_decode_skid_if #(
    parameter int unsigned PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [PC_W-1:0] in_pc;
    logic [31:0]     in_inst;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [24:0]     out_inst_31_7;
    logic [2:0]      out_imm_type;
    logic            out_illegal;

    // Seen from the decode stage.
    modport slave (
        input  in_valid, in_pc, in_inst, flush, out_ready,
        output in_ready, out_valid, out_pc, out_inst_31_7, out_imm_type, out_illegal
    );

    // Seen from the environment driving fetch and consuming decode.
    modport master (
        output in_valid, in_pc, in_inst, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_inst_31_7, out_imm_type, out_illegal
    );
endinterface

// File: rtl/imm_decode_skid_imm_type_decode.sv
// Combinational opcode/funct3 classifier producing the immediate type.
module imm_type_decode
    import imm_decode_skid_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic [6:0] opcode_i,
    output imm_type_e  imm_type_o,
    output logic       illegal_o
);

    // Map the major opcode to its immediate format; unknown opcodes flag illegal.
    always_comb begin
        imm_type_o = R_TYPE;
        illegal_o  = 1'b0;
        case (opcode_i)
            OPC_OP:     imm_type_o = R_TYPE;
            OPC_OPIMM:  imm_type_o = (funct3_i == 3'b001 || funct3_i == 3'b101) ? ISTAR_TYPE : I_TYPE;
            OPC_LOAD,
            OPC_JALR,
            OPC_SYSTEM: imm_type_o = I_TYPE;
            OPC_STORE:  imm_type_o = S_TYPE;
            OPC_BRANCH: imm_type_o = B_TYPE;
            OPC_LUI,
            OPC_AUIPC:  imm_type_o = U_TYPE;
            OPC_JAL:    imm_type_o = J_TYPE;
            default:    illegal_o  = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_decode_skid.sv
// Stage-1 decode front end: decodes at the input and holds decoded entries
// in a 2-entry skid buffer so ready toward fetch is purely registered.
module imm_decode_skid
    import imm_decode_skid_pkg::*;
#(
    parameter int unsigned PC_W = 32
) (
    input logic              clk,
    input logic              rst_n,
    imm_decode_skid_if.slave bus
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [24:0]     inst_31_7;
        imm_type_e       imm_type;
        logic            illegal;
    } entry_t;

    count_e    count_q, count_d;
    entry_t    head_q, head_d;
    entry_t    skid_q, skid_d;
    entry_t    in_entry;
    imm_type_e dec_type;
    logic      dec_illegal;
    logic      push, pop;

    imm_type_decode u_dec (
        .funct3_i   (bus.in_inst[14:12]),
        .opcode_i   (bus.in_inst[6:0]),
        .imm_type_o (dec_type),
        .illegal_o  (dec_illegal)
    );

    assign in_entry = '{pc: bus.in_pc, inst_31_7: bus.in_inst[31:7],
                        imm_type: dec_type, illegal: dec_illegal};

    assign bus.in_ready      = (count_q != FULL);
    assign bus.out_valid     = (count_q != EMPTY);
    assign bus.out_pc        = head_q.pc;
    assign bus.out_inst_31_7 = head_q.inst_31_7;
    assign bus.out_imm_type  = head_q.imm_type;
    assign bus.out_illegal   = head_q.illegal;

    assign push = bus.in_valid & bus.in_ready & ~bus.flush;
    assign pop  = bus.out_valid & bus.out_ready;

    // Occupancy and entry registers; reset clears everything to a known value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= EMPTY;
            head_q  <= '{pc: '0, inst_31_7: '0, imm_type: R_TYPE, illegal: 1'b0};
            skid_q  <= '{pc: '0, inst_31_7: '0, imm_type: R_TYPE, illegal: 1'b0};
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    // Next occupancy and entry movement; flush overrides every other transition.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            count_d = EMPTY;
        end else begin
            case (count_q)
                EMPTY: begin
                    if (push) begin
                        head_d  = in_entry;
                        count_d = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_d = in_entry;
                    end else if (push) begin
                        skid_d  = in_entry;
                        count_d = FULL;
                    end else if (pop) begin
                        count_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_d  = skid_q;
                        count_d = ONE;
                    end
                end
                default: count_d = EMPTY;
            endcase
        end
    end

endmodule
